// File: rtl/vend_dispense_ctrl.sv
// Dispense/change controller sitting downstream of the coin-credit FSM.
// Accepts a one-shot select or cancel while idle, releases the product for
// DISP_CYCLES cycles, then returns change one 50-unit coin at a time with
// COIN_GAP idle cycles between coins, and finally pulses clr_credit so the
// coin FSM drops back to zero credit.
//
// Handshake: sel and cancel are single-cycle triggers sampled only while the
// block is idle (busy=0); anything presented while busy=1 is ignored, and
// credit is only looked at on the edge where a trigger is accepted.
module vend_dispense_ctrl #(
  parameter logic [2:0] PRICE_CODE  = 3'd3,
  parameter int         DISP_CYCLES = 4,
  parameter int         COIN_GAP    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] credit,
  input  logic       sel,
  input  logic       cancel,
  output logic       dispense,
  output logic       coin_ret,
  output logic       clr_credit,
  output logic       deny,
  output logic       busy
);

  localparam int TMAX = (DISP_CYCLES > COIN_GAP) ? DISP_CYCLES : COIN_GAP;
  localparam int TW   = $clog2(TMAX + 1);

  // Timer is loaded with "cycles - 1" on entry so the state lasts exactly N cycles.
  localparam logic [TW-1:0] DISP_LOAD = TW'(DISP_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(COIN_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DISP = 3'd1,
    ST_CHG  = 3'd2,
    ST_GAP  = 3'd3,
    ST_CLR  = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [2:0]    chg, chg_d;
  logic [TW-1:0] timer, timer_d;
  logic [2:0]    credit_sat;
  logic          deny_d;

  // Credit codes above 4 (200 units) are saturated to 4.
  assign credit_sat = (credit > 3'd4) ? 3'd4 : credit;

  // Next-state, change counter and timer; outputs are decoded from next state.
  always_comb begin
    state_d = state;
    chg_d   = chg;
    timer_d = timer;
    deny_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel) begin
          if (credit_sat >= PRICE_CODE) begin
            chg_d   = credit_sat - PRICE_CODE;
            timer_d = DISP_LOAD;
            state_d = ST_DISP;
          end else begin
            deny_d = 1'b1;
          end
        end else if (cancel && (credit_sat != 3'd0)) begin
          chg_d   = credit_sat;
          state_d = ST_CHG;
        end
      end
      ST_DISP: begin
        if (timer == '0) begin
          state_d = (chg != 3'd0) ? ST_CHG : ST_CLR;
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      ST_CHG: begin
        // One coin goes out this cycle; the last coin leads straight to CLR.
        chg_d = chg - 3'd1;
        if (chg == 3'd1) begin
          state_d = ST_CLR;
        end else begin
          timer_d = GAP_LOAD;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (timer == '0) begin
          state_d = ST_CHG;
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      ST_CLR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset discards any pending change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      chg        <= 3'd0;
      timer      <= '0;
      dispense   <= 1'b0;
      coin_ret   <= 1'b0;
      clr_credit <= 1'b0;
      deny       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      chg        <= chg_d;
      timer      <= timer_d;
      dispense   <= (state_d == ST_DISP);
      coin_ret   <= (state_d == ST_CHG);
      clr_credit <= (state_d == ST_CLR);
      deny       <= deny_d;
      busy       <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: directed scenarios followed by random traffic.
// A transaction-level reference model turns each accepted request into the
// full list of per-cycle output vectors it should produce; a monitor compares
// the DUT against that expectation one cycle at a time.
module tb_vend_dispense_ctrl;

  localparam logic [2:0] PRICE_CODE  = 3'd3;
  localparam int         DISP_CYCLES = 4;
  localparam int         COIN_GAP    = 2;

  // Output vector layout: {dispense, coin_ret, clr_credit, deny, busy}
  localparam logic [4:0] V_IDLE = 5'b00000;
  localparam logic [4:0] V_DISP = 5'b10001;
  localparam logic [4:0] V_COIN = 5'b01001;
  localparam logic [4:0] V_CLR  = 5'b00101;
  localparam logic [4:0] V_DENY = 5'b00010;
  localparam logic [4:0] V_GAP  = 5'b00001;

  logic       clk;
  logic       rst;
  logic [2:0] credit;
  logic       sel;
  logic       cancel;
  logic       dispense;
  logic       coin_ret;
  logic       clr_credit;
  logic       deny;
  logic       busy;

  int n_checks;
  int n_fails;
  int cyc;

  logic [4:0] exp_q[$];
  logic [4:0] plan_q[$];
  logic       model_busy;

  vend_dispense_ctrl #(
    .PRICE_CODE (PRICE_CODE),
    .DISP_CYCLES(DISP_CYCLES),
    .COIN_GAP   (COIN_GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .credit    (credit),
    .sel       (sel),
    .cancel    (cancel),
    .dispense  (dispense),
    .coin_ret  (coin_ret),
    .clr_credit(clr_credit),
    .deny      (deny),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Append the coin-return sequence for n coins, with gaps between coins.
  function automatic void plan_coins(input int n);
    for (int i = 0; i < n; i++) begin
      plan_q.push_back(V_COIN);
      if (i < n - 1) begin
        for (int g = 0; g < COIN_GAP; g++) plan_q.push_back(V_GAP);
      end
    end
  endfunction

  // At every edge decide what the cycle after this edge must look like.
  always @(posedge clk) begin
    int cr;
    logic [4:0] v;
    v = V_IDLE;
    if (rst) begin
      plan_q.delete();
      model_busy = 1'b0;
    end else if (model_busy) begin
      if (plan_q.size() > 0) v = plan_q.pop_front();
    end else begin
      cr = (int'(credit) > 4) ? 4 : int'(credit);
      if (sel) begin
        if (cr >= int'(PRICE_CODE)) begin
          for (int d = 0; d < DISP_CYCLES; d++) plan_q.push_back(V_DISP);
          plan_coins(cr - int'(PRICE_CODE));
          plan_q.push_back(V_CLR);
          v = plan_q.pop_front();
        end else begin
          v = V_DENY;
        end
      end else if (cancel && cr > 0) begin
        plan_coins(cr);
        plan_q.push_back(V_CLR);
        v = plan_q.pop_front();
      end
    end
    model_busy = v[0];
    exp_q.push_back(v);
  end

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [4:0] act;
    logic [4:0] exp_v;
    #1;
    act = {dispense, coin_ret, clr_credit, deny, busy};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fails++;
      $display("FAIL scoreboard_empty cyc=%0d got=%b expected an entry", cyc, act);
    end else begin
      exp_v = exp_q.pop_front();
      if (act !== exp_v) begin
        n_fails++;
        $display("FAIL outputs cyc=%0d got {disp,coin,clr,deny,busy}=%b expected %b",
                 cyc, act, exp_v);
      end
    end
    n_checks++;
    if (($countones({dispense, coin_ret, clr_credit, deny}) > 1)) begin
      n_fails++;
      $display("FAIL exclusive_pulses cyc=%0d got %b expected at most one pulse",
               cyc, {dispense, coin_ret, clr_credit, deny});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic s, input logic c, input logic [2:0] cr);
    @(negedge clk);
    rst    = r;
    sel    = s;
    cancel = c;
    credit = cr;
  endtask

  task automatic idle_cycles(input int n, input logic [2:0] cr);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, cr);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks   = 0;
    n_fails    = 0;
    cyc        = 0;
    model_busy = 1'b0;
    rst    = 1'b1;
    sel    = 1'b0;
    cancel = 1'b0;
    credit = 3'd0;
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    idle_cycles(3, 3'd0);

    // Purchase with one coin of change.
    drive(1'b0, 1'b1, 1'b0, 3'd4);
    idle_cycles(10, 3'd4);
    // Insufficient credit -> deny.
    drive(1'b0, 1'b1, 1'b0, 3'd2);
    idle_cycles(4, 3'd2);
    // Refund of three coins.
    drive(1'b0, 1'b0, 1'b1, 3'd3);
    idle_cycles(12, 3'd3);
    // sel and cancel together: sel wins, exact price, no change.
    drive(1'b0, 1'b1, 1'b1, 3'd3);
    idle_cycles(9, 3'd3);
    // Refund interrupted by reset, then a clean purchase.
    drive(1'b0, 1'b0, 1'b1, 3'd4);
    idle_cycles(1, 3'd4);
    drive(1'b1, 1'b0, 1'b0, 3'd4);
    idle_cycles(6, 3'd3);
    drive(1'b0, 1'b1, 1'b0, 3'd3);
    idle_cycles(8, 3'd3);
    // Cancel with zero credit does nothing.
    drive(1'b0, 1'b0, 1'b1, 3'd0);
    idle_cycles(3, 3'd0);
    // Triggers while busy are ignored; credit 7 saturates to 4.
    drive(1'b0, 1'b1, 1'b0, 3'd7);
    drive(1'b0, 1'b1, 1'b0, 3'd1);
    drive(1'b0, 1'b0, 1'b1, 3'd4);
    idle_cycles(2, 3'd2);
    drive(1'b0, 1'b1, 1'b1, 3'd4);
    idle_cycles(8, 3'd4);
    // Accept on the first idle edge right after clr_credit.
    drive(1'b0, 1'b1, 1'b0, 3'd3);
    idle_cycles(4, 3'd3);
    drive(1'b0, 1'b1, 1'b0, 3'd3);
    drive(1'b0, 1'b1, 1'b0, 3'd3);
    idle_cycles(8, 3'd3);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 79) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0),
            3'($urandom_range(0, 7)));
    end
    idle_cycles(20, 3'd0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
